memory_responder: RTL and testbench

- Memory-side responder for the memory interface; the counterpart of the tester that initiates transactions.
- Samples the tester's wr/rd/addr/wr_data on the rising edge of clk. Stimulus is driven on the falling edge.
- Stores write data in an internal array and returns read data after a fixed, parameterised latency, qualified by rd_valid.
- Flags illegal commands and out-of-range addresses, and keeps saturating transaction counters for scoreboard cross-checks.

---
 rtl/memory_responder.sv | 160 ++++++++++++++++
 tb/tb_memory_responder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// -----------------------------------------------------------------------------
// memory_responder
// Memory-side responder: accepts single-cycle write/read commands, stores
// 16-bit words in a DEPTH-entry array, and returns read data after a fixed
// RD_LAT-cycle pipeline, qualified by rd_valid. Illegal commands and
// out-of-range addresses raise one-cycle error pulses, and saturating counters
// track the accepted writes and reads.
// -----------------------------------------------------------------------------
module memory_responder #(
    parameter int DEPTH  = 16,   // words stored, 1..65536
    parameter int RD_LAT = 1     // read latency in cycles, 1..4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr,
    input  logic        rd,
    input  logic [15:0] addr,
    input  logic [15:0] wr_data,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        addr_err,
    output logic        cmd_err,
    output logic [15:0] wr_count,
    output logic [15:0] rd_count
);

    // Index width into the array; a 1-word memory still needs one index bit.
    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // DEPTH may be 65536, so the range compare is done on 17 bits.
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [15:0]       mem_q [DEPTH];
    logic [RD_LAT-1:0] pipe_valid_q, pipe_valid_d;
    logic [15:0]       pipe_data_q [RD_LAT];
    logic [15:0]       pipe_data_d [RD_LAT];
    logic [15:0]       wr_count_q, wr_count_d;
    logic [15:0]       rd_count_q, rd_count_d;
    logic              addr_err_q, addr_err_d;
    logic              cmd_err_q,  cmd_err_d;

    // -------------------------------------------------------------------------
    // Command decode
    // -------------------------------------------------------------------------
    logic          cmd_bad;   // wr and rd together: command is dropped
    logic          in_range;  // address falls inside the array
    logic          wr_ok;     // write that actually updates memory
    logic          rd_any;    // single read command, in or out of range
    logic          rd_ok;     // read that is counted and returns array data
    logic [AW-1:0] idx;
    logic [15:0]   rd_word;

    assign cmd_bad  = wr & rd;
    assign in_range = {1'b0, addr} < DEPTH_W;
    assign wr_ok    = wr & ~rd & in_range;
    assign rd_any   = rd & ~wr;
    assign rd_ok    = rd_any & in_range;
    // Only the low index bits are used, and only once the range check passed.
    assign idx      = addr[AW-1:0];
    // Out-of-range reads still complete, but return zero.
    assign rd_word  = rd_ok ? mem_q[idx] : 16'h0000;

    // Storage array: written on accepted writes, cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: every word is a flop with an async clear, so reset really
        // zeroes the contents; an SRAM macro would not give this for free.
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 16'h0000;
            end
        end else if (wr_ok) begin
            // NOTE: non-blocking, so a read on this same edge would still
            // see the old word; reads on later edges see the new one.
            mem_q[idx] <= wr_data;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------

    // Read pipeline shift: stage 0 captures at the request edge, the last
    // stage drives the outputs; data only moves with a valid token so
    // rd_data holds its last value while rd_valid is low.
    always_comb begin
        // NOTE: defaults first so every path assigns every bit (no latch).
        pipe_valid_d = '0;
        pipe_data_d  = pipe_data_q;
        pipe_valid_d[0] = rd_any;
        if (rd_any) begin
            pipe_data_d[0] = rd_word;
        end
        for (int k = 1; k < RD_LAT; k++) begin
            pipe_valid_d[k] = pipe_valid_q[k-1];
            if (pipe_valid_q[k-1]) begin
                pipe_data_d[k] = pipe_data_q[k-1];
            end
        end
    end

    // Saturating counters and one-cycle error pulses.
    always_comb begin
        wr_count_d = wr_count_q;
        rd_count_d = rd_count_q;
        if (wr_ok && (wr_count_q != 16'hFFFF)) begin
            wr_count_d = wr_count_q + 16'd1;
        end
        if (rd_ok && (rd_count_q != 16'hFFFF)) begin
            rd_count_d = rd_count_q + 16'd1;
        end
        cmd_err_d  = cmd_bad;
        // Range errors are only reported for a single, legal command.
        addr_err_d = (wr ^ rd) & ~in_range;
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------

    // Read pipeline registers; reset flushes every in-flight read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_valid_q <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                pipe_data_q[k] <= 16'h0000;
            end
        end else begin
            pipe_valid_q <= pipe_valid_d;
            pipe_data_q  <= pipe_data_d;
        end
    end

    // Counter and error-flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_count_q <= 16'h0000;
            rd_count_q <= 16'h0000;
            addr_err_q <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            wr_count_q <= wr_count_d;
            rd_count_q <= rd_count_d;
            addr_err_q <= addr_err_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign rd_valid = pipe_valid_q[RD_LAT-1];
    assign rd_data  = pipe_data_q[RD_LAT-1];
    assign addr_err = addr_err_q;
    assign cmd_err  = cmd_err_q;
    assign wr_count = wr_count_q;
    assign rd_count = rd_count_q;

endmodule

// File: tb/tb_memory_responder.sv
// -----------------------------------------------------------------------------
// tb_memory_responder
// Drives two responders (RD_LAT=1 and RD_LAT=3) with the same stimulus. A
// behavioural model turns each accepted command into expected responses that
// are queued with the edge at which they are due; a negedge monitor pops and
// compares whatever the DUTs present.
// -----------------------------------------------------------------------------
module tb_memory_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr, rd;
    logic [15:0] addr, wr_data;

    logic [15:0] rd_data1, wr_count1, rd_count1;
    logic        rd_valid1, addr_err1, cmd_err1;
    logic [15:0] rd_data3, wr_count3, rd_count3;
    logic        rd_valid3, addr_err3, cmd_err3;

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;

    always #5 clk = ~clk;

    memory_responder #(.DEPTH(16), .RD_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset), .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .addr_err(addr_err1),
        .cmd_err(cmd_err1), .wr_count(wr_count1), .rd_count(rd_count1)
    );

    memory_responder #(.DEPTH(16), .RD_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset), .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data),
        .rd_data(rd_data3), .rd_valid(rd_valid3), .addr_err(addr_err3),
        .cmd_err(cmd_err3), .wr_count(wr_count3), .rd_count(rd_count3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // ---------------------------------------------------------------- model
    typedef struct {
        logic [15:0] data;
        int          due;   // value of edge_cnt when the response is visible
    } exp_t;

    exp_t        q1[$];
    exp_t        q3[$];
    logic [15:0] m_mem [16];
    int          m_wr_cnt = 0;
    int          m_rd_cnt = 0;
    logic        e_addr_err = 1'b0;
    logic        e_cmd_err  = 1'b0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    initial begin : model
        logic [15:0] val;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                for (int i = 0; i < 16; i++) m_mem[i] = 16'h0000;
                m_wr_cnt   = 0;
                m_rd_cnt   = 0;
                e_addr_err = 1'b0;
                e_cmd_err  = 1'b0;
                q1.delete();
                q3.delete();
            end else begin
                e_cmd_err  = wr && rd;
                e_addr_err = (wr != rd) && (addr >= 16);
                if (wr && !rd && addr < 16) begin
                    m_mem[addr[3:0]] = wr_data;
                    if (m_wr_cnt < 65535) m_wr_cnt++;
                end
                if (rd && !wr) begin
                    val = (addr < 16) ? m_mem[addr[3:0]] : 16'h0000;
                    // edge_cnt still holds this edge's number (NBA pending).
                    q1.push_back('{data: val, due: edge_cnt + 1});
                    q3.push_back('{data: val, due: edge_cnt + 3});
                    if (addr < 16 && m_rd_cnt < 65535) m_rd_cnt++;
                end
            end
        end
    end

    // -------------------------------------------------------------- monitor
    initial begin : monitor
        logic        ev1, ev3;
        logic [15:0] last1, last3;
        last1 = 16'h0000;
        last3 = 16'h0000;
        forever begin
            @(negedge clk);
            if (reset) begin
                last1 = 16'h0000;
                last3 = 16'h0000;
            end
            ev1 = (q1.size() > 0) && (q1[0].due == edge_cnt);
            ev3 = (q3.size() > 0) && (q3[0].due == edge_cnt);
            check("rd_valid_lat1", rd_valid1, ev1);
            check("rd_valid_lat3", rd_valid3, ev3);
            if (ev1) begin
                last1 = q1[0].data;
                void'(q1.pop_front());
            end
            if (ev3) begin
                last3 = q3[0].data;
                void'(q3.pop_front());
            end
            check("rd_data_lat1", rd_data1, last1);
            check("rd_data_lat3", rd_data3, last3);
            check("addr_err_lat1", addr_err1, e_addr_err);
            check("addr_err_lat3", addr_err3, e_addr_err);
            check("cmd_err_lat1", cmd_err1, e_cmd_err);
            check("cmd_err_lat3", cmd_err3, e_cmd_err);
            check("wr_count_lat1", wr_count1, m_wr_cnt);
            check("wr_count_lat3", wr_count3, m_wr_cnt);
            check("rd_count_lat1", rd_count1, m_rd_cnt);
            check("rd_count_lat3", rd_count3, m_rd_cnt);
        end
    end

    // ------------------------------------------------------------- stimulus
    task automatic op(input logic w, input logic r, input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        wr      = w;
        rd      = r;
        addr    = a;
        wr_data = d;
    endtask

    task automatic idle(input int n);
        repeat (n) op(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    // Reset asserted mid-cycle: outputs must clear without any clock edge.
    task automatic pulse_reset();
        @(negedge clk);
        wr = 1'b0;
        rd = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_rd_data1", rd_data1, 0);   check("rst_rd_data3", rd_data3, 0);
        check("rst_rd_valid1", rd_valid1, 0); check("rst_rd_valid3", rd_valid3, 0);
        check("rst_addr_err1", addr_err1, 0); check("rst_addr_err3", addr_err3, 0);
        check("rst_cmd_err1", cmd_err1, 0);   check("rst_cmd_err3", cmd_err3, 0);
        check("rst_wr_count1", wr_count1, 0); check("rst_wr_count3", wr_count3, 0);
        check("rst_rd_count1", rd_count1, 0); check("rst_rd_count3", rd_count3, 0);
        @(negedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin : stimulus
        int kind;
        wr = 1'b0; rd = 1'b0; addr = 16'h0000; wr_data = 16'h0000;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;

        // Make outputs non-zero, then reset with no clock edge.
        op(1'b1, 1'b0, 16'd7, 16'h0077);
        op(1'b0, 1'b1, 16'd7, 16'h0000);
        op(1'b1, 1'b1, 16'd7, 16'h0000);
        idle(4);
        pulse_reset();
        op(1'b0, 1'b1, 16'd5, 16'h0000);          // reads cleared memory
        op(1'b0, 1'b1, 16'd7, 16'h0000);          // old write was wiped
        idle(4);

        // Sequential fill then back-to-back read-out.
        pulse_reset();
        for (int i = 0; i < 16; i++) op(1'b1, 1'b0, 16'(i), 16'(i));
        for (int i = 0; i < 16; i++) op(1'b0, 1'b1, 16'(i), 16'h0000);
        idle(4);
        check("fill_wr_count", wr_count1, 16);
        check("fill_rd_count", rd_count3, 16);

        // Write then read the same address on adjacent edges.
        op(1'b1, 1'b0, 16'd3, 16'hA5A5);
        op(1'b0, 1'b1, 16'd3, 16'h0000);
        // Illegal command leaves mem[2] at 2.
        op(1'b1, 1'b1, 16'd2, 16'h1234);
        op(1'b0, 1'b1, 16'd2, 16'h0000);
        // Out-of-range write and read.
        op(1'b1, 1'b0, 16'h0010, 16'hBEEF);
        op(1'b0, 1'b1, 16'h0000, 16'h0000);
        op(1'b0, 1'b1, 16'hFFFF, 16'h0000);
        idle(4);

        // Three reads in flight, then reset flushes the ones not yet out.
        op(1'b0, 1'b1, 16'd1, 16'h0000);
        op(1'b0, 1'b1, 16'd3, 16'h0000);
        op(1'b0, 1'b1, 16'd4, 16'h0000);
        pulse_reset();
        idle(5);

        // Randomised mix.
        for (int n = 0; n < 50; n++) begin
            kind = $urandom_range(0, 9);
            if (kind < 4)
                op(1'b1, 1'b0, 16'($urandom_range(0, 15)), 16'($urandom));
            else if (kind < 8)
                op(1'b0, 1'b1, 16'($urandom_range(0, 15)), 16'h0000);
            else if (kind == 8)
                op(1'b1, 1'b1, 16'($urandom_range(0, 15)), 16'($urandom));
            else
                idle(1);
        end
        idle(6);
        check("drained_lat1", q1.size(), 0);
        check("drained_lat3", q3.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
